// File: rtl/accel_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | accel_pkg : shared types and defaults for the accelerator WB initiator    |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
package accel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_A    = 3'd1,
    ST_WR_B    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_RD_RES  = 3'd4,
    ST_RD_STAT = 3'd5,
    ST_RESP    = 3'd6
  } accel_wbm_state_t;

  typedef enum logic [1:0] {
    BC_IDLE = 2'd0,
    BC_BUSY = 2'd1,
    BC_GAP  = 2'd2
  } accel_bc_state_t;

  localparam logic [7:0] DEF_ADDR_A     = 8'h00;
  localparam logic [7:0] DEF_ADDR_B     = 8'h04;
  localparam logic [7:0] DEF_ADDR_RES   = 8'h08;
  localparam logic [7:0] DEF_ADDR_STAT  = 8'h0C;
  localparam int         DEF_SETTLE_CYC = 2;
  localparam int         DEF_MAX_RETRY  = 3;
  localparam int         STAT_OVF_BIT   = 0;

  typedef struct packed {
    logic [15:0] result;
    logic        overflow;
    logic        error;
  } accel_rsp_t;

  localparam accel_rsp_t RSP_ERROR = '{result: 16'h0000, overflow: 1'b0, error: 1'b1};

endpackage
`default_nettype wire

// File: rtl/accel_wbm_bus_cycle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | accel_wbm_bus_cycle : one Wishbone classic access with retry/watchdog     |
// | Optional watchdog: ACCEL_WBM_TIMEOUT_EN                 Rev 1.0           |
// +--------------------------------------------------------------------------+
module accel_wbm_bus_cycle
  import accel_pkg::*;
#(
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [7:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  accel_bc_state_t state_q, state_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            redo_q, redo_d;
  logic            fail_q, fail_d;
  logic            we_q, we_d;
  logic [7:0]      adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            load;
`ifdef ACCEL_WBM_TIMEOUT_EN
  logic [9:0]      wdog_q, wdog_d;
`endif

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    redo_d  = redo_q;
    fail_d  = fail_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    done_o  = 1'b0;
    err_o   = 1'b0;
    load    = 1'b0;
`ifdef ACCEL_WBM_TIMEOUT_EN
    wdog_d  = wdog_q;
`endif
    case (state_q)
      BC_IDLE: load = start_i;
      BC_BUSY: begin
        // err outranks rty, which outranks ack
        if (wb_err_i) begin
          fail_d  = 1'b1;
          state_d = BC_GAP;
        end else if (wb_rty_i) begin
          if (retry_q == RW'(MAX_RETRY)) begin
            fail_d = 1'b1;
          end else begin
            retry_d = retry_q + 1'b1;
            redo_d  = 1'b1;
          end
          state_d = BC_GAP;
        end else if (wb_ack_i) begin
          retry_d = '0;
          rdata_d = wb_dat_i;
          state_d = BC_GAP;
        end
`ifdef ACCEL_WBM_TIMEOUT_EN
        // this idle strobe cycle would bring the watchdog to 1023
        else if (wdog_q == 10'h3FE) begin
          fail_d  = 1'b1;
          state_d = BC_GAP;
        end else begin
          wdog_d = wdog_q + 10'd1;
        end
`endif
      end
      BC_GAP: begin
        if (redo_q) begin
          redo_d  = 1'b0;
          state_d = BC_BUSY;
`ifdef ACCEL_WBM_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end else begin
          done_o  = 1'b1;
          err_o   = fail_q;
          state_d = BC_IDLE;
          load    = start_i;
        end
      end
      default: state_d = BC_IDLE;
    endcase
    if (load) begin
      state_d = BC_BUSY;
      we_d    = we_i;
      adr_d   = adr_i;
      dat_d   = dat_i;
      retry_d = '0;
      redo_d  = 1'b0;
      fail_d  = 1'b0;
`ifdef ACCEL_WBM_TIMEOUT_EN
      wdog_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BC_IDLE;
      retry_q <= '0;
      redo_q  <= 1'b0;
      fail_q  <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
`ifdef ACCEL_WBM_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      redo_q  <= redo_d;
      fail_q  <= fail_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
`ifdef ACCEL_WBM_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign wb_cyc_o = (state_q == BC_BUSY);
  assign wb_stb_o = (state_q == BC_BUSY);
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign rdata_o  = rdata_q;

endmodule
`default_nettype wire

// File: rtl/accel_wb_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | accel_wb_master : WB classic initiator sequencing one accelerator op      |
// | Optional watchdog: ACCEL_WBM_TIMEOUT_EN                 Rev 1.0           |
// +--------------------------------------------------------------------------+
module accel_wb_master
  import accel_pkg::*;
#(
  parameter logic [7:0] ADDR_A     = DEF_ADDR_A,
  parameter logic [7:0] ADDR_B     = DEF_ADDR_B,
  parameter logic [7:0] ADDR_RES   = DEF_ADDR_RES,
  parameter logic [7:0] ADDR_STAT  = DEF_ADDR_STAT,
  parameter int         SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int         MAX_RETRY  = DEF_MAX_RETRY
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [15:0] req_a_i,
  input  logic [15:0] req_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_result_o,
  output logic        rsp_overflow_o,
  output logic        rsp_error_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  accel_wbm_state_t state_q, state_d;
  logic [15:0]      b_q, b_d;
  logic [3:0]       settle_q, settle_d;
  accel_rsp_t       rsp_q, rsp_d;
  logic             bc_start, bc_we, bc_done, bc_err;
  logic [7:0]       bc_adr;
  logic [31:0]      bc_dat, bc_rdata;
  logic             unused_rdata;

  assign unused_rdata = ^bc_rdata[31:16];

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    settle_d = settle_q;
    rsp_d    = rsp_q;
    bc_start = 1'b0;
    bc_we    = 1'b0;
    bc_adr   = '0;
    bc_dat   = '0;
    case (state_q)
      ST_IDLE: if (req_valid_i) begin
        b_d      = req_b_i;
        rsp_d    = '0;
        bc_start = 1'b1;
        bc_we    = 1'b1;
        bc_adr   = ADDR_A;
        bc_dat   = {16'h0000, req_a_i};
        state_d  = ST_WR_A;
      end
      ST_WR_A: if (bc_done) begin
        if (bc_err) begin
          rsp_d   = RSP_ERROR;
          state_d = ST_RESP;
        end else begin
          bc_start = 1'b1;
          bc_we    = 1'b1;
          bc_adr   = ADDR_B;
          bc_dat   = {16'h0000, b_q};
          state_d  = ST_WR_B;
        end
      end
      ST_WR_B: if (bc_done) begin
        if (bc_err) begin
          rsp_d   = RSP_ERROR;
          state_d = ST_RESP;
        end else if (SETTLE_CYC == 0) begin
          bc_start = 1'b1;
          bc_adr   = ADDR_RES;
          state_d  = ST_RD_RES;
        end else begin
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          bc_start = 1'b1;
          bc_adr   = ADDR_RES;
          state_d  = ST_RD_RES;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_RD_RES: if (bc_done) begin
        if (bc_err) begin
          rsp_d   = RSP_ERROR;
          state_d = ST_RESP;
        end else begin
          rsp_d.result = bc_rdata[15:0];
          bc_start     = 1'b1;
          bc_adr       = ADDR_STAT;
          state_d      = ST_RD_STAT;
        end
      end
      ST_RD_STAT: if (bc_done) begin
        if (bc_err) begin
          rsp_d = RSP_ERROR;
        end else begin
          rsp_d.overflow = bc_rdata[STAT_OVF_BIT];
          rsp_d.error    = 1'b0;
        end
        state_d = ST_RESP;
      end
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q  <= ST_IDLE;
      b_q      <= '0;
      settle_q <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      settle_q <= settle_d;
      rsp_q    <= rsp_d;
    end
  end

  accel_wbm_bus_cycle #(
    .MAX_RETRY (MAX_RETRY)
  ) u_bus_cycle (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_i),
    .start_i  (bc_start),
    .we_i     (bc_we),
    .adr_i    (bc_adr),
    .dat_i    (bc_dat),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .wb_rty_i (wb_rty_i),
    .done_o   (bc_done),
    .err_o    (bc_err),
    .rdata_o  (bc_rdata)
  );

  assign req_ready_o    = (state_q == ST_IDLE);
  assign rsp_valid_o    = (state_q == ST_RESP);
  assign rsp_result_o   = rsp_q.result;
  assign rsp_overflow_o = rsp_q.overflow;
  assign rsp_error_o    = rsp_q.error;
  assign wb_sel_o       = 4'hF;
  assign wb_cti_o       = 3'b000;
  assign wb_bte_o       = 2'b00;

endmodule
`default_nettype wire
